// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions
// Purpose: receiver/transmitter state encodings and the bit-timing helper.
// Ports: none (package).
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // Clocks per serial bit; clock given in MHz, baud in bit/s, integer division.
    function automatic int unsigned clocks_per_bit(input int unsigned clk_fre_mhz,
                                                   input int unsigned baud_rate);
        return (clk_fre_mhz * 32'd1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
// Purpose: bring an asynchronous level into the clk domain.
// Ports:
//   clk  in   clock
//   rst  in   synchronous reset, active-high; both flops load RESET_VAL
//   d    in   asynchronous input
//   q    out  synchronized output
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output
// Purpose: mid-bit sampling receiver, LSB first, one stop bit.
// Ports:
//   clk            in   clock
//   rst            in   synchronous reset, active-high
//   rx_pin         in   asynchronous serial line, idle high
//   rx_data        out  [7:0] received byte, stable while rx_data_valid
//   rx_data_valid  out  byte available
//   rx_data_ready  in   consumer accepts the byte
//   rx_frame_err   out  one-cycle pulse: stop bit sampled low
//   rx_overrun     out  one-cycle pulse: unread byte overwritten
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRE   = 27,
    parameter int unsigned BAUD_RATE = 5625
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned CYCLE = clocks_per_bit(CLK_FRE, BAUD_RATE);
    localparam int unsigned HALF  = CYCLE / 2;

    localparam logic [31:0] CYCLE_LAST = 32'(CYCLE - 1);
    localparam logic [31:0] HALF_LAST  = 32'(HALF - 1);

    logic        rx_s;
    logic        rx_s_prev;
    logic        fall;

    uart_state_t state, state_next;
    logic [31:0] cycle_cnt, cycle_cnt_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  shift, shift_next;
    logic        deliver;
    logic        frame_err_set;

    uart_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_pin),
        .q   (rx_s)
    );

    // A true 1->0 transition is required; a line stuck low never re-arms.
    assign fall = rx_s_prev & ~rx_s;

    always_comb begin
        state_next     = state;
        cycle_cnt_next = cycle_cnt + 32'd1;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift;
        deliver        = 1'b0;
        frame_err_set  = 1'b0;

        case (state)
            S_IDLE: begin
                cycle_cnt_next = 32'd0;
                if (fall) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (cycle_cnt == HALF_LAST) begin
                    cycle_cnt_next = 32'd0;
                    if (!rx_s) begin
                        state_next   = S_DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        // Start bit gone by mid-point: treat as a glitch.
                        state_next = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cycle_cnt == CYCLE_LAST) begin
                    cycle_cnt_next      = 32'd0;
                    shift_next[bit_cnt] = rx_s;
                    bit_cnt_next        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end

            S_STOP: begin
                // Leaving at the stop mid-point leaves half a bit to catch
                // a back-to-back start edge.
                if (cycle_cnt == CYCLE_LAST) begin
                    cycle_cnt_next = 32'd0;
                    state_next     = S_IDLE;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end
            end

            default: begin
                state_next     = S_IDLE;
                cycle_cnt_next = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cycle_cnt <= 32'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            rx_s_prev <= 1'b1;
        end else begin
            state     <= state_next;
            cycle_cnt <= cycle_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            rx_s_prev <= rx_s;
        end
    end

    // Output side: the byte lands the cycle after the stop sample decision.
    // A transfer on the delivery cycle consumes the old byte, so it is not
    // an overrun and valid simply stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= 8'd0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err <= frame_err_set;
            rx_overrun   <= deliver & rx_data_valid & ~rx_data_ready;
            if (deliver) begin
                rx_data       <= shift;
                rx_data_valid <= 1'b1;
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule
